// File: rtl/trace_capture_buf.sv
// Triggered capture buffer for neuron-emulator trace probes: ring-buffers samples,
// freezes a pre/post-trigger window on a threshold crossing, then streams it out.
module trace_capture_buf #(
  parameter int unsigned WIDTH    = 25,
  parameter int unsigned DEPTH    = 256,
  parameter int unsigned AW       = 8,
  parameter int unsigned PRE_TRIG = 32
) (
  input  logic                    emu_clk,
  input  logic                    emu_rst_n,
  input  logic                    emu_dec_cmp,
  input  logic [63:0]             emu_time,
  input  logic [WIDTH-1:0]        v_out_probe,
  input  logic [WIDTH-1:0]        i_in_probe,
  input  logic [WIDTH-1:0]        trig_level,
  input  logic                    arm,
  input  logic                    force_trig,
  input  logic                    abort,
  output logic                    busy,
  output logic                    triggered,
  output logic                    done,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic [32+2*WIDTH-1:0]   rd_data,
  output logic                    rd_last
);

  localparam int unsigned DW = 32 + 2 * WIDTH;
  localparam int unsigned CW = AW + 1;

  localparam logic [CW-1:0] PRE_CNT_MAX = CW'(PRE_TRIG);
  localparam logic [CW-1:0] POST_XING   = CW'(DEPTH - PRE_TRIG - 1);
  localparam logic [CW-1:0] POST_FORCE  = CW'(DEPTH - PRE_TRIG);
  localparam logic [CW-1:0] LAST_IDX    = CW'(DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C     = CW'(DEPTH);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PRE   = 3'd1;
  localparam logic [2:0] S_ARMED = 3'd2;
  localparam logic [2:0] S_POST  = 3'd3;
  localparam logic [2:0] S_READ  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    pre_cnt_q, pre_cnt_d;
  logic [CW-1:0]    post_cnt_q, post_cnt_d;
  logic [CW-1:0]    iss_cnt_q, iss_cnt_d;
  logic [CW-1:0]    ld_cnt_q, ld_cnt_d;
  logic [WIDTH-1:0] lvl_q, lvl_d;
  logic [WIDTH-1:0] prev_v_q, prev_v_d;
  logic             prev_valid_q, prev_valid_d;
  logic             triggered_q, triggered_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             rd_valid_q, rd_valid_d;
  logic             rd_last_q, rd_last_d;
  logic [DW-1:0]    rd_data_q, rd_data_d;
  logic             mem_vld_q, mem_vld_d;

  logic [DW-1:0]    mem [DEPTH];
  logic [DW-1:0]    mem_rdata;
  logic             wr_en, rd_en, sampling, xing, xfer, move;

  logic unused_time_hi;
  assign unused_time_hi = ^emu_time[63:32];

  assign busy      = busy_q;
  assign triggered = triggered_q;
  assign done      = done_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign rd_last   = rd_last_q;

  // Next-state, capture and readout-pipeline logic
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    pre_cnt_d    = pre_cnt_q;
    post_cnt_d   = post_cnt_q;
    iss_cnt_d    = iss_cnt_q;
    ld_cnt_d     = ld_cnt_q;
    lvl_d        = lvl_q;
    prev_v_d     = prev_v_q;
    prev_valid_d = prev_valid_q;
    triggered_d  = triggered_q;
    rd_valid_d   = rd_valid_q;
    rd_last_d    = rd_last_q;
    rd_data_d    = rd_data_q;
    mem_vld_d    = mem_vld_q;
    wr_en        = 1'b0;
    rd_en        = 1'b0;
    move         = 1'b0;

    // A POST entry with nothing left to collect must not overwrite the oldest entry
    sampling = emu_dec_cmp && ((state_q == S_PRE) || (state_q == S_ARMED) ||
               ((state_q == S_POST) && (post_cnt_q != '0)));
    xing = prev_valid_q && ($signed(prev_v_q) < $signed(lvl_q)) &&
           ($signed(v_out_probe) >= $signed(lvl_q));
    xfer = rd_valid_q && rd_ready;

    if (abort) begin
      state_d     = S_IDLE;
      triggered_d = 1'b0;
      rd_valid_d  = 1'b0;
      rd_last_d   = 1'b0;
      mem_vld_d   = 1'b0;
    end else begin
      if (sampling) begin
        wr_en    = 1'b1;
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      case (state_q)
        S_IDLE, S_DONE: begin
          if (arm) begin
            lvl_d        = trig_level;
            wr_ptr_d     = '0;
            pre_cnt_d    = '0;
            triggered_d  = 1'b0;
            prev_valid_d = 1'b0;
            state_d      = S_PRE;
          end
        end
        S_PRE: begin
          if (sampling) begin
            pre_cnt_d    = pre_cnt_q + CW'(1);
            prev_v_d     = v_out_probe;
            prev_valid_d = 1'b1;
            if (pre_cnt_q + CW'(1) == PRE_CNT_MAX) state_d = S_ARMED;
          end
        end
        S_ARMED: begin
          if (sampling) begin
            prev_v_d     = v_out_probe;
            prev_valid_d = 1'b1;
          end
          if (sampling && (xing || force_trig)) begin
            triggered_d = 1'b1;
            post_cnt_d  = POST_XING;
            state_d     = S_POST;
          end else if (force_trig) begin
            triggered_d = 1'b1;
            post_cnt_d  = POST_FORCE;
            state_d     = S_POST;
          end
        end
        S_POST: begin
          if (sampling) post_cnt_d = post_cnt_q - CW'(1);
          if ((post_cnt_q == '0) || (sampling && (post_cnt_q == CW'(1)))) begin
            state_d   = S_READ;
            rd_ptr_d  = wr_ptr_d;
            iss_cnt_d = '0;
            ld_cnt_d  = '0;
            mem_vld_d = 1'b0;
          end
        end
        S_READ: begin
          // Two-stage pipe: RAM read register feeds the output register
          move = mem_vld_q && (!rd_valid_q || xfer);
          if (xfer) begin
            rd_valid_d = 1'b0;
            rd_last_d  = 1'b0;
          end
          if (move) begin
            rd_valid_d = 1'b1;
            rd_data_d  = mem_rdata;
            rd_last_d  = (ld_cnt_q == LAST_IDX);
            ld_cnt_d   = ld_cnt_q + CW'(1);
          end
          if ((!mem_vld_q || move) && (iss_cnt_q != DEPTH_C)) begin
            rd_en     = 1'b1;
            rd_ptr_d  = rd_ptr_q + AW'(1);
            iss_cnt_d = iss_cnt_q + CW'(1);
            mem_vld_d = 1'b1;
          end else if (move) begin
            mem_vld_d = 1'b0;
          end
          if (xfer && rd_last_q) state_d = S_DONE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    busy_d = (state_d == S_PRE) || (state_d == S_ARMED) ||
             (state_d == S_POST) || (state_d == S_READ);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge emu_clk or negedge emu_rst_n) begin
    if (!emu_rst_n) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      pre_cnt_q    <= '0;
      post_cnt_q   <= '0;
      iss_cnt_q    <= '0;
      ld_cnt_q     <= '0;
      lvl_q        <= '0;
      prev_v_q     <= '0;
      prev_valid_q <= 1'b0;
      triggered_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_last_q    <= 1'b0;
      rd_data_q    <= '0;
      mem_vld_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      pre_cnt_q    <= pre_cnt_d;
      post_cnt_q   <= post_cnt_d;
      iss_cnt_q    <= iss_cnt_d;
      ld_cnt_q     <= ld_cnt_d;
      lvl_q        <= lvl_d;
      prev_v_q     <= prev_v_d;
      prev_valid_q <= prev_valid_d;
      triggered_q  <= triggered_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      rd_valid_q   <= rd_valid_d;
      rd_last_q    <= rd_last_d;
      rd_data_q    <= rd_data_d;
      mem_vld_q    <= mem_vld_d;
    end
  end

  // Sample RAM with registered read port; contents need no reset
  always_ff @(posedge emu_clk) begin
    if (wr_en) mem[wr_ptr_q] <= {emu_time[31:0], i_in_probe, v_out_probe};
    if (rd_en) mem_rdata <= mem[rd_ptr_q];
  end

endmodule

// File: tb/tb_trace_capture_buf.sv
// Scoreboard bench for trace_capture_buf at DEPTH=16, PRE_TRIG=4.
module tb_trace_capture_buf;

  localparam int unsigned W     = 25;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;
  localparam int unsigned PRE   = 4;
  localparam int unsigned DW    = 32 + 2 * W;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  logic          emu_clk = 1'b0;
  logic          emu_rst_n;
  logic          emu_dec_cmp;
  logic [63:0]   emu_time;
  logic [W-1:0]  v_out_probe, i_in_probe, trig_level;
  logic          arm, force_trig, abort;
  logic          busy, triggered, done, rd_valid, rd_ready, rd_last;
  logic [DW-1:0] rd_data;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  logic mon_en = 1'b1;
  logic stall_mode = 1'b0;

  trace_capture_buf #(.WIDTH(W), .DEPTH(DEPTH), .AW(AW), .PRE_TRIG(PRE)) dut (
    .emu_clk(emu_clk), .emu_rst_n(emu_rst_n), .emu_dec_cmp(emu_dec_cmp),
    .emu_time(emu_time), .v_out_probe(v_out_probe), .i_in_probe(i_in_probe),
    .trig_level(trig_level), .arm(arm), .force_trig(force_trig), .abort(abort),
    .busy(busy), .triggered(triggered), .done(done), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last)
  );

  always #5 emu_clk = ~emu_clk;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  function automatic logic [DW-1:0] word(input int base, input int n, input int v);
    return {32'(base + n), W'(-3 * n), W'(v)};
  endfunction

  task automatic tick();
    @(posedge emu_clk);
    #1;
  endtask

  task automatic sample(input int base, input int n, input int v);
    emu_dec_cmp = 1'b1;
    emu_time    = {32'hDEAD_BEEF, 32'(base + n)};
    v_out_probe = W'(v);
    i_in_probe  = W'(-3 * n);
    tick();
    emu_dec_cmp = 1'b0;
    tick();
    tick();
  endtask

  task automatic do_arm();
    trig_level = W'(100);
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic push_window(input int base, input int first_n, input int vals[DEPTH]);
    for (int k = 0; k < DEPTH; k++) begin
      exp_t e;
      e.data = word(base, first_n + k, vals[k]);
      e.last = (k == DEPTH - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_done(input string name);
    int cyc = 0;
    while (done !== 1'b1 && cyc < 200) begin
      tick();
      cyc++;
    end
    chk({name, "_done"}, DW'(done), DW'(1));
    chk({name, "_trig"}, DW'(triggered), DW'(1));
    chk({name, "_busy"}, DW'(busy), DW'(0));
    chk({name, "_rdv"}, DW'(rd_valid), DW'(0));
    chk({name, "_drained"}, DW'(exp_q.size()), DW'(0));
  endtask

  // Ramp capture: v = 10*(n-1), crossing of 100 at n=11, window n=7..22
  task automatic ramp_capture(input int base, input string name);
    int vals[DEPTH];
    for (int k = 0; k < DEPTH; k++) vals[k] = 60 + 10 * k;
    push_window(base, 7, vals);
    do_arm();
    chk({name, "_busy_arm"}, DW'(busy), DW'(1));
    for (int n = 1; n <= 10; n++) sample(base, n, 10 * (n - 1));
    chk({name, "_pre_trig"}, DW'(triggered), DW'(0));
    sample(base, 11, 100);
    chk({name, "_post_trig"}, DW'(triggered), DW'(1));
    for (int n = 12; n <= 22; n++) sample(base, n, 10 * (n - 1));
    wait_done(name);
  endtask

  // Readout sink: always ready, or the 1,0,0,1 pattern
  initial begin
    int k = 0;
    rd_ready = 1'b1;
    forever begin
      @(posedge emu_clk);
      #1;
      if (stall_mode) begin
        rd_ready = ((k % 4) == 0) || ((k % 4) == 3);
        k++;
      end else begin
        rd_ready = 1'b1;
      end
    end
  end

  // Monitor: compares every presented word against the scoreboard head
  initial begin
    forever begin
      @(negedge emu_clk);
      if (mon_en && emu_rst_n && rd_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", rd_data, '0);
        end else if (rd_ready) begin
          exp_t e;
          e = exp_q.pop_front();
          chk("rd_data", rd_data, e.data);
          chk("rd_last", DW'(rd_last), DW'(e.last));
        end else begin
          chk("stall_hold", rd_data, exp_q[0].data);
        end
      end
    end
  end

  initial begin
    int vals[DEPTH];
    emu_rst_n = 1'b0;
    emu_dec_cmp = 1'b0; emu_time = '0; v_out_probe = '0; i_in_probe = '0;
    trig_level = '0; arm = 1'b0; force_trig = 1'b0; abort = 1'b0;
    #23;
    chk("rst_busy", DW'(busy), DW'(0));
    chk("rst_trig", DW'(triggered), DW'(0));
    chk("rst_done", DW'(done), DW'(0));
    chk("rst_rdv", DW'(rd_valid), DW'(0));
    chk("rst_last", DW'(rd_last), DW'(0));
    chk("rst_data", rd_data, '0);
    emu_rst_n = 1'b1;
    tick();

    ramp_capture(1000, "ramp");

    // Constant 150 never crosses; force_trig with no strobe then 12 more samples
    for (int k = 0; k < DEPTH; k++) vals[k] = 150;
    push_window(2000, 21, vals);
    do_arm();
    for (int n = 1; n <= 24; n++) sample(2000, n, 150);
    chk("force_pre_trig", DW'(triggered), DW'(0));
    force_trig = 1'b1;
    tick();
    force_trig = 1'b0;
    chk("force_trig", DW'(triggered), DW'(1));
    for (int n = 25; n <= 36; n++) sample(2000, n, 150);
    wait_done("force");

    // Crossing inside PRE is ignored; second rise at n=6 triggers; stalled readout
    for (int k = 0; k < DEPTH; k++) vals[k] = 200;
    vals[3] = 0;
    push_window(3000, 2, vals);
    stall_mode = 1'b1;
    do_arm();
    sample(3000, 1, 0);
    for (int n = 2; n <= 4; n++) sample(3000, n, 200);
    sample(3000, 5, 0);
    chk("pre_xing_ignored", DW'(triggered), DW'(0));
    sample(3000, 6, 200);
    chk("armed_xing", DW'(triggered), DW'(1));
    for (int n = 7; n <= 17; n++) sample(3000, n, 200);
    wait_done("prexing");
    stall_mode = 1'b0;

    // Abort in POST with 3 samples remaining, then a clean capture
    do_arm();
    for (int n = 1; n <= 19; n++) sample(4000, n, 10 * (n - 1));
    chk("abort_pre_trig", DW'(triggered), DW'(1));
    chk("abort_pre_busy", DW'(busy), DW'(1));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", DW'(busy), DW'(0));
    chk("abort_trig", DW'(triggered), DW'(0));
    ramp_capture(5000, "rearm");

    // Asynchronous reset in the middle of READ
    for (int k = 0; k < DEPTH; k++) vals[k] = 60 + 10 * k;
    push_window(6000, 7, vals);
    do_arm();
    for (int n = 1; n <= 22; n++) sample(6000, n, 10 * (n - 1));
    begin
      int cyc = 0;
      while (rd_valid !== 1'b1 && cyc < 20) begin
        tick();
        cyc++;
      end
      chk("read_started", DW'(rd_valid), DW'(1));
    end
    @(negedge emu_clk);
    #2;
    mon_en = 1'b0;
    emu_rst_n = 1'b0;
    #1;
    chk("arst_rdv", DW'(rd_valid), DW'(0));
    chk("arst_busy", DW'(busy), DW'(0));
    chk("arst_done", DW'(done), DW'(0));
    exp_q.delete();
    #3;
    emu_rst_n = 1'b1;
    tick();
    tick();
    chk("post_rst_data", rd_data, '0);
    chk("post_rst_busy", DW'(busy), DW'(0));
    chk("post_rst_done", DW'(done), DW'(0));
    chk("post_rst_rdv", DW'(rd_valid), DW'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
